// File: rtl/fixed_divider_seq_if.sv
// Operand/result handshake bundle for the sequential QM.N divider.
// master drives operands and takes results; slave is the divider.
interface fixed_divider_seq_if #(parameter int W = 24);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_num;
   logic [W-1:0] in_den;
   logic         in_abs;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         out_sat;

   modport master (
      output in_valid, in_num, in_den, in_abs, out_ready,
      input  in_ready, out_valid, out_data, out_sat
   );

   modport slave (
      input  in_valid, in_num, in_den, in_abs, out_ready,
      output in_ready, out_valid, out_data, out_sat
   );
endinterface

// File: rtl/fixed_divider_seq.sv
// Iterative signed QM.N divider: restoring division on magnitudes, one quotient
// bit per clock, truncation toward zero, saturation on overflow and divide-by-zero.
module fixed_divider_seq #(
   parameter int M = 12,
   parameter int N = 12
) (
   input logic                clk,
   input logic                reset,
   fixed_divider_seq_if.slave bus
);
   localparam int W  = M + N;
   localparam int K  = W + N;
   localparam int CW = $clog2(K + 1);

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

   state_t         r_state, w_state_nxt;
   logic [K-1:0]   r_dvd;
   logic [K-1:0]   r_quo;
   logic [W-1:0]   r_rem;
   logic [W-1:0]   r_den;
   logic [CW-1:0]  r_cnt;
   logic           r_neg;
   logic           r_zero;
   logic [W-1:0]   r_out_data;
   logic           r_out_sat;

   logic           w_accept;
   logic           w_iter_done;
   logic [W-1:0]   w_num_abs;
   logic [W-1:0]   w_den_abs;
   logic [W:0]     w_rem_sh;
   logic           w_ge;
   logic [W-1:0]   w_rem_nxt;
   logic           w_sat;
   logic [W-1:0]   w_mag;
   logic [W-1:0]   w_res;

   assign w_accept    = bus.in_valid && (r_state == S_IDLE);
   assign w_iter_done = (r_cnt == CW'(K));

   // Two's-complement negate as unsigned W bits: the most negative input maps to 2^(W-1).
   assign w_num_abs = bus.in_num[W-1] ? (~bus.in_num + 1'b1) : bus.in_num;
   assign w_den_abs = bus.in_den[W-1] ? (~bus.in_den + 1'b1) : bus.in_den;

   // Remainder stays below |den| <= 2^(W-1), so W bits hold it between steps.
   assign w_rem_sh  = {r_rem, r_dvd[K-1]};
   assign w_ge      = (w_rem_sh >= {1'b0, r_den});
   assign w_rem_nxt = w_ge ? W'(w_rem_sh - {1'b0, r_den}) : w_rem_sh[W-1:0];

   assign w_sat = r_zero || (|r_quo[K-1:W-1]);
   assign w_mag = w_sat ? {1'b0, {(W-1){1'b1}}} : r_quo[W-1:0];
   assign w_res = r_neg ? (~w_mag + 1'b1) : w_mag;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: if (bus.in_valid)  w_state_nxt = S_DIV;
         S_DIV:  if (w_iter_done)   w_state_nxt = S_DONE;
         S_DONE: if (bus.out_ready) w_state_nxt = S_IDLE;
         default:                   w_state_nxt = S_IDLE;
      endcase
   end

   // K iteration cycles, then one cycle that forms the signed result from the finished quotient.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_dvd      <= '0;
         r_quo      <= '0;
         r_rem      <= '0;
         r_den      <= '0;
         r_cnt      <= '0;
         r_neg      <= 1'b0;
         r_zero     <= 1'b0;
         r_out_data <= '0;
         r_out_sat  <= 1'b0;
      end else if (w_accept) begin
         r_dvd  <= {w_num_abs, {N{1'b0}}};
         r_den  <= w_den_abs;
         r_neg  <= (bus.in_num[W-1] ^ bus.in_den[W-1]) & ~bus.in_abs;
         r_zero <= (bus.in_den == '0);
         r_rem  <= '0;
         r_quo  <= '0;
         r_cnt  <= '0;
      end else if (r_state == S_DIV) begin
         if (!w_iter_done) begin
            r_rem <= w_rem_nxt;
            r_dvd <= {r_dvd[K-2:0], 1'b0};
            r_quo <= {r_quo[K-2:0], w_ge};
            r_cnt <= r_cnt + CW'(1);
         end else begin
            r_out_data <= w_res;
            r_out_sat  <= w_sat;
         end
      end
   end

   assign bus.in_ready  = (r_state == S_IDLE);
   assign bus.out_valid = (r_state == S_DONE);
   assign bus.out_data  = r_out_data;
   assign bus.out_sat   = r_out_sat;
endmodule
